// File: rtl/mvm3_pkg.sv
// Shared types and sizing for the 3x3 matrix-vector multiply controller.
package mvm3_pkg;

    localparam int unsigned M       = 3;
    localparam int unsigned M_WORDS = M * M;
    localparam int unsigned AW      = $clog2(M_WORDS);
    localparam int unsigned XW      = $clog2(M);

    typedef enum logic [2:0] {
        LOAD_M,
        LOAD_X,
        COMPUTE,
        DRAIN,
        OUTPUT
    } mvm3_state_t;

endpackage

// File: rtl/mvm3_ctrl_if.sv
// Controller <-> stream/datapath signal bundle.
interface mvm3_ctrl_if;
    import mvm3_pkg::*;

    logic          s_valid;
    logic          s_ready;
    logic          m_valid;
    logic          m_ready;
    logic          wr_en_m;
    logic          wr_en_x;
    logic [AW-1:0] addr_m;
    logic [XW-1:0] addr_x;
    logic          clear_acc;
    logic          en_acc;
    logic [XW-1:0] row_idx;

    // Controller side
    modport master (
        input  s_valid, m_ready,
        output s_ready, m_valid, wr_en_m, wr_en_x, addr_m, addr_x,
               clear_acc, en_acc, row_idx
    );

    // Stream source / sink / datapath side
    modport slave (
        output s_valid, m_ready,
        input  s_ready, m_valid, wr_en_m, wr_en_x, addr_m, addr_x,
               clear_acc, en_acc, row_idx
    );

endinterface

// File: rtl/mvm3_idx_cnt.sv
// Mod-N index counter with synchronous clear and a registered terminal-count flag.
module mvm3_idx_cnt #(
    parameter int unsigned N = 3,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         last_q, last_d;

    // Next count: clear wins over increment, increment wraps at N-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = last_q ? '0 : cnt_q + W'(1);
        end
        last_d = (cnt_d == W'(N - 1));
    end

    // Count and terminal flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            last_q <= (N == 1);
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = last_q;

endmodule

// File: rtl/mvm3_ctrl.sv
// Sequencer for the 3x3 matrix-vector unit: load matrix, load vector, then per row
// issue M reads, drain the MAC pipeline and present the row until accepted.
module mvm3_ctrl
    import mvm3_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    mvm3_ctrl_if.master bus
);

    mvm3_state_t   state_q;
    logic          s_ready_q;
    logic          m_valid_q;
    logic          en_acc_q;
    logic          clear_acc_q;

    logic [AW-1:0] cnt;
    logic [XW-1:0] row;
    logic [XW-1:0] col;
    logic          cnt_last, row_last, col_last;
    logic          cnt_en, cnt_clr, row_en, row_clr, col_en, col_clr;

    logic          xfer_c;
    logic          hs_c;
    logic          wr_en_m_c, wr_en_x_c;
    logic [AW-1:0] addr_m_c;
    logic [XW-1:0] addr_x_c;

    mvm3_idx_cnt #(.N(M_WORDS), .W(AW)) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (cnt_en),
        .clr_i   (cnt_clr),
        .cnt_o   (cnt),
        .last_o  (cnt_last)
    );

    mvm3_idx_cnt #(.N(M), .W(XW)) u_row (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (row_en),
        .clr_i   (row_clr),
        .cnt_o   (row),
        .last_o  (row_last)
    );

    mvm3_idx_cnt #(.N(M), .W(XW)) u_col (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (col_en),
        .clr_i   (col_clr),
        .cnt_o   (col),
        .last_o  (col_last)
    );

    // Handshakes, memory write/read addressing and counter control
    always_comb begin
        xfer_c    = bus.s_valid & s_ready_q;
        hs_c      = m_valid_q & bus.m_ready;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        row_en    = 1'b0;
        row_clr   = 1'b0;
        col_en    = 1'b0;
        col_clr   = 1'b0;
        wr_en_m_c = 1'b0;
        wr_en_x_c = 1'b0;
        addr_m_c  = '0;
        addr_x_c  = '0;
        unique case (state_q)
            LOAD_M: begin
                wr_en_m_c = xfer_c;
                addr_m_c  = cnt;
                cnt_en    = xfer_c;
            end
            LOAD_X: begin
                wr_en_x_c = xfer_c;
                addr_x_c  = XW'(cnt);
                cnt_en    = xfer_c;
                cnt_clr   = xfer_c & (cnt == AW'(M - 1));
            end
            COMPUTE: begin
                addr_m_c = AW'(row) * AW'(M) + AW'(col);
                addr_x_c = col;
                col_en   = 1'b1;
            end
            OUTPUT: begin
                if (hs_c) begin
                    col_clr = 1'b1;
                    if (row_last) begin
                        row_clr = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        row_en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // State sequencing with registered handshake flags and MAC strobe pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD_M;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            en_acc_q    <= 1'b0;
            clear_acc_q <= 1'b0;
        end else begin
            en_acc_q    <= (state_q == COMPUTE);
            clear_acc_q <= (state_q == COMPUTE) && (col == '0);
            unique case (state_q)
                LOAD_M: begin
                    if (xfer_c && cnt_last) begin
                        state_q <= LOAD_X;
                    end
                end
                LOAD_X: begin
                    if (cnt_clr) begin
                        state_q   <= COMPUTE;
                        s_ready_q <= 1'b0;
                    end
                end
                COMPUTE: begin
                    if (col_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q   <= OUTPUT;
                    m_valid_q <= 1'b1;
                end
                OUTPUT: begin
                    if (hs_c) begin
                        m_valid_q <= 1'b0;
                        if (row_last) begin
                            state_q   <= LOAD_M;
                            s_ready_q <= 1'b1;
                        end else begin
                            state_q <= COMPUTE;
                        end
                    end
                end
                default: begin
                    state_q   <= LOAD_M;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = m_valid_q;
    assign bus.wr_en_m   = wr_en_m_c;
    assign bus.wr_en_x   = wr_en_x_c;
    assign bus.addr_m    = addr_m_c;
    assign bus.addr_x    = addr_x_c;
    assign bus.en_acc    = en_acc_q;
    assign bus.clear_acc = clear_acc_q;
    assign bus.row_idx   = row;

endmodule

// File: tb/tb_mvm3_ctrl.sv
// Bench for mvm3_ctrl: behavioural memories + MAC around the controller, results
// compared with a direct matrix-vector product of the streamed data.
module tb_mvm3_ctrl;
    import mvm3_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mvm3_ctrl_if bus();

    mvm3_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] data_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_xfer  = 0;
    int first_xfer = 0;
    int hs_cyc     = 0;
    bit hold_rdy   = 1'b0;

    // Datapath stand-in: memories with one-cycle read and the accumulator
    logic [31:0]   mem_m [M_WORDS];
    logic [31:0]   mem_x [M];
    logic [31:0]   rd_m, rd_x, acc;
    logic [AW-1:0] rd_addr_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en_m) mem_m[bus.addr_m] <= data_in;
        if (bus.wr_en_x) mem_x[bus.addr_x] <= data_in;
        rd_m      <= mem_m[bus.addr_m];
        rd_x      <= mem_x[bus.addr_x];
        rd_addr_q <= bus.addr_m;
        if (bus.en_acc) acc <= bus.clear_acc ? rd_m * rd_x : acc + rd_m * rd_x;
    end

    // Protocol observation between edges
    int wrm = 0, wrx = 0, en_in_row = 0, bad_clr = 0, bad_wr = 0, bad_en = 0;
    logic [AW-1:0] rd_log [$];

    always @(negedge clk) begin
        if (!reset_n) begin
            en_in_row <= 0;
        end else begin
            if (bus.wr_en_m) wrm <= wrm + 1;
            if (bus.wr_en_x) wrx <= wrx + 1;
            if ((bus.wr_en_m || bus.wr_en_x) && bus.s_valid !== 1'b1) bad_wr <= bad_wr + 1;
            if (bus.clear_acc && !(bus.en_acc && en_in_row == 0)) bad_clr <= bad_clr + 1;
            if (bus.en_acc && bus.m_valid) bad_en <= bad_en + 1;
            if (bus.en_acc) begin
                en_in_row <= en_in_row + 1;
                rd_log.push_back(rd_addr_q);
            end
            if (bus.m_valid && bus.m_ready) en_in_row <= 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_row(input logic [31:0] a [M_WORDS],
                                            input logic [31:0] x [M], input int r);
        logic [31:0] s = 32'd0;
        for (int c = 0; c < int'(M); c++) s += a[r * int'(M) + c] * x[c];
        return s;
    endfunction

    task automatic send_word(input logic [31:0] w, input bit gaps);
        bit done = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.s_valid = 1'b0;
                data_in     = 'x;
                @(posedge clk); #1;
            end
        end
        bus.s_valid = 1'b1;
        data_in     = w;
        for (int k = 0; k < 20 && !done; k++) begin
            if (bus.s_ready === 1'b1) done = 1'b1;
            @(posedge clk); #1;
        end
        if (done) last_xfer = cyc;
        else chk("s_ready_timeout", 32'(done), 32'd1);
        bus.s_valid = 1'b0;
        data_in     = 'x;
    endtask

    task automatic load(input logic [31:0] a [M_WORDS], input logic [31:0] x [M], input bit gaps);
        for (int i = 0; i < int'(M_WORDS); i++) begin
            send_word(a[i], gaps);
            if (i == 0) first_xfer = last_xfer;
        end
        for (int i = 0; i < int'(M); i++) send_word(x[i], gaps);
    endtask

    task automatic take_row(input int r, input logic [31:0] exp, input int stall, input int ref_cyc);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.m_valid === 1'b1) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("m_valid_timeout", 32'(seen), 32'd1);
        if (seen) begin
            chk("latency", 32'(cyc - ref_cyc), 32'(M + 1));
            chk("row_idx", 32'(bus.row_idx), 32'(r));
            chk("result", acc, exp);
            chk("en_acc_per_row", 32'(en_in_row), 32'(M));
            for (int s = 0; s < stall; s++) begin
                bus.m_ready = 1'b0;
                @(posedge clk); #1;
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_row", 32'(bus.row_idx), 32'(r));
            end
            bus.m_ready = 1'b1;
            @(posedge clk); #1;
            hs_cyc      = cyc;
            bus.m_ready = hold_rdy;
            chk("valid_drop", 32'(bus.m_valid), 32'd0);
            if (r == int'(M) - 1) chk("reload_ready", 32'(bus.s_ready), 32'd1);
        end
    endtask

    task automatic take_rows(input logic [31:0] a [M_WORDS], input logic [31:0] x [M], input int stall_max);
        for (int r = 0; r < int'(M); r++)
            take_row(r, ref_row(a, x, r), $urandom_range(0, stall_max), (r == 0) ? last_xfer : hs_cyc);
    endtask

    logic [31:0] a_b [M_WORDS];
    logic [31:0] x_b [M];
    logic [31:0] a_d [M_WORDS];
    logic [31:0] x_d [M];
    logic [31:0] a_r [M_WORDS];
    logic [31:0] x_r [M];
    int base_m, base_x, base_log, t0;

    initial begin
        reset_n     = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        data_in     = 'x;
        a_b = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
        x_b = '{32'd1, 32'd2, 32'd3};
        a_d = '{32'd2, 32'd0, 32'd0, 32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd2};
        x_d = '{32'd5, 32'd6, 32'd7};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_wr_en_m", 32'(bus.wr_en_m), 32'd0);
        chk("rst_en_acc", 32'(bus.en_acc), 32'd0);
        chk("rst_addr_m", 32'(bus.addr_m), 32'd0);
        chk("rst_row_idx", 32'(bus.row_idx), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // basic load and output, no gaps
        base_m = wrm; base_x = wrx; base_log = rd_log.size(); t0 = cyc;
        hold_rdy = 1'b1; bus.m_ready = 1'b1;
        load(a_b, x_b, 1'b0);
        chk("no_bubbles", 32'(last_xfer - t0), 32'd12);
        chk("s_ready_drop", 32'(bus.s_ready), 32'd0);
        take_rows(a_b, x_b, 0);
        chk("known_row2", ref_row(a_b, x_b, 2), 32'd50);
        chk("writes_m", 32'(wrm - base_m), 32'd9);
        chk("writes_x", 32'(wrx - base_x), 32'd3);
        chk("read_count", 32'(rd_log.size() - base_log), 32'd9);
        for (int i = 0; i < int'(M_WORDS); i++)
            if (base_log + i < rd_log.size()) chk("read_addr", 32'(rd_log[base_log + i]), 32'(i));

        // randomized handshakes, same data
        hold_rdy = 1'b0; bus.m_ready = 1'b0;
        load(a_b, x_b, 1'b1);
        take_rows(a_b, x_b, 5);

        // random data with a long output stall on row 0
        for (int i = 0; i < int'(M_WORDS); i++) a_r[i] = 32'($urandom_range(0, 255));
        for (int i = 0; i < int'(M); i++) x_r[i] = 32'($urandom_range(0, 255));
        load(a_r, x_r, 1'b1);
        take_row(0, ref_row(a_r, x_r, 0), 20, last_xfer);
        take_row(1, ref_row(a_r, x_r, 1), 0, hs_cyc);
        take_row(2, ref_row(a_r, x_r, 2), 3, hs_cyc);

        // reset during row 1 compute, then reload
        load(a_b, x_b, 1'b0);
        take_row(0, ref_row(a_b, x_b, 0), 0, last_xfer);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_en_acc", 32'(bus.en_acc), 32'd0);
        chk("mid_rst_clear", 32'(bus.clear_acc), 32'd0);
        chk("mid_rst_addr_m", 32'(bus.addr_m), 32'd0);
        chk("mid_rst_addr_x", 32'(bus.addr_x), 32'd0);
        chk("mid_rst_row_idx", 32'(bus.row_idx), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        load(a_d, x_d, 1'b1);
        take_rows(a_d, x_d, 2);

        // back-to-back matrices with m_ready held high
        hold_rdy = 1'b1; bus.m_ready = 1'b1;
        for (int i = 0; i < int'(M_WORDS); i++) a_r[i] = 32'($urandom_range(0, 255));
        for (int i = 0; i < int'(M); i++) x_r[i] = 32'($urandom_range(0, 255));
        load(a_r, x_r, 1'b0);
        take_rows(a_r, x_r, 0);
        t0 = hs_cyc;
        for (int i = 0; i < int'(M_WORDS); i++) a_r[i] = 32'($urandom_range(0, 255));
        for (int i = 0; i < int'(M); i++) x_r[i] = 32'($urandom_range(0, 255));
        load(a_r, x_r, 1'b0);
        chk("b2b_start", 32'(first_xfer - t0), 32'd1);
        take_rows(a_r, x_r, 0);

        // protocol monitors
        @(negedge clk);
        chk("write_without_valid", 32'(bad_wr), 32'd0);
        chk("clear_not_first", 32'(bad_clr), 32'd0);
        chk("en_acc_in_output", 32'(bad_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
